// File: rtl/order_sequencer.sv
`default_nettype none
// ============================================================================
// order_sequencer : keypad order entry (preset / custom amounts) and mixer
//                   req/ack/done handshake.            Revision 1.0
// ============================================================================
module order_sequencer #(
   parameter int                              N_CH         = 6,
   parameter int                              AMT_W        = 4,
   parameter int                              N_PRESET     = 5,
   parameter logic [N_PRESET*N_CH*AMT_W-1:0]  PRESET_TABLE = '0,
   parameter logic [31:0]                     TIMEOUT      = 32'd0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  key_valid,
   input  logic [3:0]            key_code,
   input  logic                  mix_ack,
   input  logic                  mix_done,
   output logic                  mix_req,
   output logic                  mix_abort,
   output logic [N_CH*AMT_W-1:0] amounts,
   output logic [3:0]            sel,
   output logic [N_CH-1:0]       ch_onehot,
   output logic [AMT_W-1:0]      entry,
   output logic [1:0]            state_o
);

   localparam int               CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int               VEC_W      = N_CH * AMT_W;
   localparam int               WIDE_W     = AMT_W + 4;
   localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(N_CH - 1);
   localparam logic [AMT_W-1:0] AMT_MAX    = {AMT_W{1'b1}};
   localparam logic [3:0]       CUSTOM_SEL = 4'(N_PRESET + 1);
   localparam logic [3:0]       KEY_ENTER  = 4'hA;
   localparam logic [3:0]       KEY_ESC    = 4'hB;
   localparam logic [3:0]       KEY_BKSP   = 4'hC;

   typedef enum logic [1:0] {
      ST_ORDER  = 2'd0,
      ST_CUSTOM = 2'd1,
      ST_REQ    = 2'd2,
      ST_RUN    = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         sel_q, sel_d;
   logic [VEC_W-1:0]   amounts_q, amounts_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [AMT_W-1:0]   entry_q, entry_d;
   logic [31:0]        tmo_q, tmo_d;
   logic               mix_req_q, mix_req_d;
   logic               mix_abort_q, mix_abort_d;
   logic [N_CH-1:0]    ch_onehot_q, ch_onehot_d;

   logic               is_digit, is_enter, is_esc, is_bksp;
   logic               timeout_hit, go_idle;
   logic [WIDE_W-1:0]  entry_wide;
   logic [CH_W-1:0]    ch_prev;

   assign is_digit = key_valid && (key_code <= 4'd9);
   assign is_enter = key_valid && (key_code == KEY_ENTER);
   assign is_esc   = key_valid && (key_code == KEY_ESC);
   assign is_bksp  = key_valid && (key_code == KEY_BKSP);
   assign ch_prev  = ch_q - CH_W'(1);

   // Widened multiply-accumulate so an overflowing entry saturates instead of wrapping
   assign entry_wide  = ({4'd0, entry_q} * WIDE_W'(10)) + WIDE_W'(key_code);
   assign timeout_hit = (TIMEOUT != 32'd0) && !key_valid && (tmo_q == TIMEOUT - 32'd1);

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      amounts_d   = amounts_q;
      ch_d        = ch_q;
      entry_d     = entry_q;
      tmo_d       = tmo_q;
      mix_abort_d = 1'b0;
      go_idle     = 1'b0;

      case (state_q)
         ST_ORDER: begin
            if (is_digit) begin
               sel_d = ((key_code >= 4'd1) && (key_code <= CUSTOM_SEL)) ? key_code : 4'd0;
            end else if (is_esc) begin
               sel_d = 4'd0;
            end else if (is_enter && (sel_q == CUSTOM_SEL)) begin
               state_d   = ST_CUSTOM;
               amounts_d = '0;
               ch_d      = '0;
               entry_d   = '0;
               tmo_d     = 32'd0;
            end else if (is_enter && (sel_q != 4'd0)) begin
               for (int p = 1; p <= N_PRESET; p++) begin
                  if (sel_q == 4'(p)) amounts_d = PRESET_TABLE[(p-1)*VEC_W +: VEC_W];
               end
               state_d = ST_REQ;
            end
         end

         ST_CUSTOM: begin
            tmo_d = key_valid ? 32'd0 : tmo_q + 32'd1;
            if (is_esc || timeout_hit) begin
               go_idle = 1'b1;
            end else if (is_digit) begin
               entry_d = (entry_wide > WIDE_W'(AMT_MAX)) ? AMT_MAX : entry_wide[AMT_W-1:0];
            end else if (is_bksp) begin
               if (entry_q != '0) begin
                  entry_d = '0;
               end else if (ch_q != '0) begin
                  ch_d = ch_prev;
                  amounts_d[int'(ch_prev)*AMT_W +: AMT_W] = '0;
               end
            end else if (is_enter) begin
               amounts_d[int'(ch_q)*AMT_W +: AMT_W] = entry_q;
               entry_d = '0;
               if (ch_q != LAST_CH) begin
                  ch_d = ch_q + CH_W'(1);
               end else if (amounts_d == '0) begin
                  go_idle = 1'b1;
               end else begin
                  state_d = ST_REQ;
               end
            end
         end

         ST_REQ: begin
            // Acceptance by the mixer takes priority over a late escape
            if (mix_ack) state_d = ST_RUN;
            else if (is_esc) go_idle = 1'b1;
         end

         default: begin
            if (mix_done) begin
               go_idle = 1'b1;
            end else if (is_esc) begin
               go_idle     = 1'b1;
               mix_abort_d = 1'b1;
            end
         end
      endcase

      if (go_idle) begin
         state_d   = ST_ORDER;
         sel_d     = 4'd0;
         amounts_d = '0;
         entry_d   = '0;
         ch_d      = '0;
         tmo_d     = 32'd0;
      end

      mix_req_d = (state_d == ST_REQ);
      for (int c = 0; c < N_CH; c++) begin
         ch_onehot_d[c] = (state_d == ST_CUSTOM) && (ch_d == CH_W'(c));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_ORDER;
         sel_q       <= 4'd0;
         amounts_q   <= '0;
         ch_q        <= '0;
         entry_q     <= '0;
         tmo_q       <= 32'd0;
         mix_req_q   <= 1'b0;
         mix_abort_q <= 1'b0;
         ch_onehot_q <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         amounts_q   <= amounts_d;
         ch_q        <= ch_d;
         entry_q     <= entry_d;
         tmo_q       <= tmo_d;
         mix_req_q   <= mix_req_d;
         mix_abort_q <= mix_abort_d;
         ch_onehot_q <= ch_onehot_d;
      end
   end

   assign mix_req   = mix_req_q;
   assign mix_abort = mix_abort_q;
   assign amounts   = amounts_q;
   assign sel       = sel_q;
   assign ch_onehot = ch_onehot_q;
   assign entry     = entry_q;
   assign state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_order_sequencer.sv
`default_nettype none
// ============================================================================
// tb_order_sequencer : directed + random keypad/mixer traffic against a
//                      queue-based reference model.     Revision 1.0
// ============================================================================
module tb_order_sequencer;

   localparam logic [119:0] PRESETS = {24'h900000, 24'h234567, 24'hFFFFFF,
                                       24'h400321, 24'h100005};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'd0;
   logic        mix_ack = 1'b0;
   logic        mix_done = 1'b0;
   logic        mix_req, mix_abort;
   logic [23:0] amounts;
   logic [3:0]  sel;
   logic [5:0]  ch_onehot;
   logic [3:0]  entry;
   logic [1:0]  state_o;

   order_sequencer #(
      .N_CH(6), .AMT_W(4), .N_PRESET(5), .PRESET_TABLE(PRESETS), .TIMEOUT(32'd20)
   ) dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
      .mix_ack(mix_ack), .mix_done(mix_done), .mix_req(mix_req),
      .mix_abort(mix_abort), .amounts(amounts), .sel(sel),
      .ch_onehot(ch_onehot), .entry(entry), .state_o(state_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  st;
      logic        req;
      logic        ab;
      logic [23:0] amt;
      logic [3:0]  sel;
      logic [5:0]  oh;
      logic [3:0]  ent;
   } snap_t;

   snap_t exp_q[$];
   int    total = 0;
   int    bad   = 0;

   // Reference model: modes 0 ORDER, 1 CUSTOM, 2 REQ, 3 RUN
   int preset [1:5][0:5] = '{'{5,0,0,0,0,1}, '{1,2,3,0,0,4}, '{15,15,15,15,15,15},
                             '{7,6,5,4,3,2}, '{0,0,0,0,0,9}};
   int m_state, m_sel, m_ch, m_entry, m_tmo;
   int m_amt [0:5];
   bit m_abort;

   function automatic void model_idle();
      m_state = 0; m_sel = 0; m_ch = 0; m_entry = 0; m_tmo = 0;
      for (int c = 0; c < 6; c++) m_amt[c] = 0;
   endfunction

   function automatic void model_reset();
      model_idle();
      m_abort = 0;
   endfunction

   function automatic void model_step(input bit kv, input int kc, input bit ack, input bit done);
      bit dig = kv && (kc <= 9);
      bit ent = kv && (kc == 10);
      bit esc = kv && (kc == 11);
      bit bk  = kv && (kc == 12);
      int sum;
      m_abort = 0;
      case (m_state)
         0: begin
            if (dig) m_sel = (kc >= 1 && kc <= 6) ? kc : 0;
            else if (esc) m_sel = 0;
            else if (ent && m_sel >= 1 && m_sel <= 5) begin
               for (int c = 0; c < 6; c++) m_amt[c] = preset[m_sel][c];
               m_state = 2;
            end else if (ent && m_sel == 6) begin
               model_idle();
               m_sel = 6;
               m_state = 1;
            end
         end
         1: begin
            if (kv) m_tmo = 0; else m_tmo++;
            if (esc || (!kv && m_tmo == 20)) model_idle();
            else if (dig) m_entry = (m_entry * 10 + kc > 15) ? 15 : m_entry * 10 + kc;
            else if (bk) begin
               if (m_entry != 0) m_entry = 0;
               else if (m_ch > 0) begin m_ch--; m_amt[m_ch] = 0; end
            end else if (ent) begin
               m_amt[m_ch] = m_entry;
               m_entry = 0;
               sum = 0;
               for (int c = 0; c < 6; c++) sum += m_amt[c];
               if (m_ch < 5) m_ch++;
               else if (sum == 0) model_idle();
               else m_state = 2;
            end
         end
         2: begin
            if (ack) m_state = 3;
            else if (esc) model_idle();
         end
         default: begin
            if (done) model_idle();
            else if (esc) begin model_idle(); m_abort = 1; end
         end
      endcase
   endfunction

   function automatic snap_t model_snap();
      snap_t s;
      s.st  = 2'(m_state);
      s.req = (m_state == 2);
      s.ab  = m_abort;
      for (int c = 0; c < 6; c++) s.amt[c*4 +: 4] = 4'(m_amt[c]);
      s.sel = 4'(m_sel);
      s.oh  = (m_state == 1) ? 6'(1 << m_ch) : 6'd0;
      s.ent = 4'(m_entry);
      return s;
   endfunction

   task automatic cyc(input bit kv, input int kc, input bit ack, input bit done);
      @(negedge clk);
      rst = 1'b0; key_valid = kv; key_code = 4'(kc); mix_ack = ack; mix_done = done;
      model_step(kv, kc, ack, done);
      exp_q.push_back(model_snap());
   endtask

   task automatic key(input int kc);
      cyc(1'b1, kc, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic reset_cycle();
      @(negedge clk);
      rst = 1'b1; key_valid = 1'b0; mix_ack = 1'b0; mix_done = 1'b0;
      model_reset();
      exp_q.push_back(model_snap());
      #1;
      total++;
      if (state_o !== 2'd0 || mix_req !== 1'b0 || amounts !== 24'd0 || sel !== 4'd0) begin
         bad++;
         $display("FAIL async_reset: got st=%0d req=%b amt=%h sel=%0d, want st=0 req=0 amt=0 sel=0",
                  state_o, mix_req, amounts, sel);
      end
   endtask

   // Monitor: one expected snapshot per clock, compared shortly after the edge
   initial begin : monitor
      snap_t e, a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state_o, mix_req, mix_abort, amounts, sel, ch_onehot, entry};
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL snapshot %0d @%0t: got st=%0d req=%b ab=%b amt=%h sel=%0d oh=%b ent=%0d | want st=%0d req=%b ab=%b amt=%h sel=%0d oh=%b ent=%0d",
                        total, $time, a.st, a.req, a.ab, a.amt, a.sel, a.oh, a.ent,
                        e.st, e.req, e.ab, e.amt, e.sel, e.oh, e.ent);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      int r;
      model_reset();
      repeat (2) reset_cycle();
      idle(1);

      // Preset 2 through the full handshake
      key(2); key(10); idle(2);
      cyc(1'b0, 0, 1'b1, 1'b0); idle(2);
      cyc(1'b0, 0, 1'b0, 1'b1); idle(1);

      // Custom entry with saturation, then escape from REQ without abort
      key(6); key(10);
      key(1); key(2); key(10);
      key(9); key(9); key(10);
      key(0); key(10);
      key(3); key(10);
      key(0); key(10);
      key(5); key(10);
      idle(2); key(11); idle(1);

      // Backspace clears entry, then steps back one channel
      key(6); key(10); key(1); key(10); key(2); key(10);
      key(7); key(12); key(12); key(12); key(11);

      // Empty custom order is rejected
      key(6); key(10);
      for (int i = 0; i < 6; i++) key(10);
      idle(2);

      // Idle timeout with one restarting keypress
      key(6); key(10); idle(19); key(4); idle(19); idle(1); idle(1);

      // Abort from RUN, done+escape, ack+escape
      key(1); key(10); cyc(1'b0, 0, 1'b1, 1'b0); idle(1); key(11); idle(1);
      key(3); key(10); cyc(1'b0, 0, 1'b1, 1'b0); cyc(1'b1, 11, 1'b0, 1'b1); idle(1);
      key(4); key(10); cyc(1'b1, 11, 1'b1, 1'b0); idle(1); cyc(1'b0, 0, 1'b0, 1'b1);

      // Ignored codes and asynchronous reset in the middle of RUN
      key(13); key(15); key(5); key(10); cyc(1'b0, 0, 1'b1, 1'b0); idle(1);
      reset_cycle(); idle(2);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 2) idle(22);
         else begin
            bit kv = ($urandom_range(0, 99) < 45);
            int kc;
            bit ack, done;
            r  = int'($urandom_range(0, 99));
            kc = (r < 55) ? int'($urandom_range(0, 9)) :
                 (r < 80) ? 10 : (r < 88) ? 12 : (r < 92) ? 11 : int'($urandom_range(13, 15));
            ack  = (m_state == 2) && ($urandom_range(0, 99) < 30);
            done = (m_state == 3) && ($urandom_range(0, 99) < 20);
            cyc(kv, kc, ack, done);
         end
      end

      idle(1);
      repeat (3) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/order_sequencer.md
# order_sequencer

Parametrised drink-order controller that turns decoded keypad events into a validated per-channel amount vector and hands it to the mixer over a req/ack/done handshake. It generalises the fixed six-ingredient order FSM to N_CH channels of AMT_W-bit amounts with a parameter-supplied preset table. It adds multi-digit saturating entry, backspace, cancel, idle timeout and mid-mix abort. It sits between the keyboard decoder/keymap and the mixer; its state, selection and channel outputs feed the VGA and 7-segment displays.

## Interface
- N_CH, 6, number of ingredient channels (1..8)
- AMT_W, 4, bits per channel amount
- N_PRESET, 5, preset drinks selected by digits 1..N_PRESET; digit N_PRESET+1 selects custom (N_PRESET+1 ≤ 9)
- PRESET_TABLE, 0, N_PRESET*N_CH*AMT_W bits; preset p (1-based), channel c at bits [((p-1)*N_CH+c)*AMT_W +: AMT_W]
- TIMEOUT, 0, 32-bit count of idle clk cycles in CUSTOM before auto-cancel; 0 disables
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- key_valid  in  1  one-cycle key event strobe
- key_code  in  4  0..9 digit, 4'hA enter, 4'hB escape, 4'hC backspace; others ignored
- mix_ack  in  1  mixer accepted request
- mix_done  in  1  one-cycle pulse, mix finished
- mix_req  out  1  request, held until ack
- mix_abort  out  1  one-cycle abort pulse to mixer
- amounts  out  N_CH*AMT_W  channel c at [c*AMT_W +: AMT_W]
- sel  out  4  current selection, 0 = none
- ch_onehot  out  N_CH  channel under entry in CUSTOM, else 0
- entry  out  AMT_W  digit accumulator
- state_o  out  2  0 ORDER, 1 CUSTOM, 2 REQ, 3 RUN

## Operation
- ORDER: digit 1..N_PRESET+1 → sel=digit; digit 0, or a digit > N_PRESET+1 → sel=0. Escape → sel=0. Enter with sel=0 ignored. Enter with a preset → amounts loaded from PRESET_TABLE, go REQ. Enter with custom → amounts=0, ch=0, entry=0, go CUSTOM.
- CUSTOM, digit d: entry = min(entry*10+d, 2^AMT_W−1). Use a saturating compare on a widened intermediate; never wrap.
- CUSTOM, backspace: if entry≠0 → entry=0. Else if ch>0 → ch−=1 and amounts[ch]=0 (the channel now current). Else no effect.
- CUSTOM, enter: amounts[ch]=entry, entry=0.
  - ch<N_CH−1 → ch+1.
  - Last channel with the final amounts vector all zero → reject: go ORDER, sel=0.
  - Last channel otherwise → go REQ.
  - Zero is a legal amount for an individual channel.
- CUSTOM, escape or timeout → ORDER; amounts, entry and sel cleared.
- Timeout counter: cleared on entry to CUSTOM and on any key_valid; it counts every other CUSTOM cycle. Reaching TIMEOUT acts as escape.
- REQ: mix_req=1, amounts frozen. mix_ack → RUN. Escape without ack → ORDER, cleared, no abort pulse. Ack together with escape → ack wins (RUN), escape dropped.
- RUN: mix_req=0, amounts held stable for the mixer. Digits, enter and backspace are ignored.
  - mix_done → ORDER; sel and amounts cleared.
  - Escape → mix_abort=1 for one cycle, go ORDER, cleared.
  - mix_done and escape in the same cycle → done wins, no abort.
- key_code values outside the defined set are ignored in every state.

## Timing
- All outputs registered. Every response appears on the clk edge that samples the causing event (visible the following cycle). Latency is 1 cycle.
- Reset: state ORDER, mix_req=0, mix_abort=0, amounts=0, sel=0, ch_onehot=0, entry=0, timeout counter=0.
- rst mid-REQ/RUN: immediate return to reset values. No abort pulse is issued; the mixer is reset by the same rst.
- mix_abort is never high for more than one cycle and only leaves RUN.
- mix_req rises the cycle after entering REQ and falls the cycle after ack is sampled.
- key_valid is assumed one cycle wide. At most one key is processed per cycle.

## Test plan
- Preset, with N_PRESET=5 and preset 2 = {1,2,3,0,0,4}: keys 2, enter → state REQ, amounts match preset 2, mix_req=1. Then ack → RUN; then mix_done → ORDER, amounts=0, sel=0.
- Custom, AMT_W=4: keys 6, enter, then per channel "1","2"(=12), "9","9"(sat 15), "0", "3", "0", "5", each followed by enter → REQ, amounts {12,15,0,3,0,5}.
- Backspace in CUSTOM: on ch2 type 7, bksp → entry=0; bksp again → ch1, amounts[1]=0, ch_onehot=6'b000010.
- Empty custom: six enters with no digits → ORDER, sel=0, mix_req never asserted.
- Timeout, TIMEOUT=20: enter CUSTOM, idle 19 cycles → still CUSTOM; a key at cycle 19 restarts the count; 20 idle cycles → ORDER, cleared.
- Abort: in RUN send escape → mix_abort one-cycle pulse, ORDER. Repeat with escape coincident with mix_done → no pulse, ORDER. Ack coincident with escape in REQ → RUN.
